// File: rtl/serial_frame_scheduler.sv
// serial_frame_scheduler
// Round-robin scheduler sharing one serial line among NREQ frame sources.
// A granted requester's port, length and payload are latched, then sent as:
// start bit (0), PW port bits, LW length bits, len payload bits (all MSB first),
// and one idle-high gap bit. All sequencing advances only on clkEn ticks.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clkEn        bit-rate enable
//   req          per-requester level request
//   port_in      flattened port fields, requester i at [i*PW +: PW]
//   len_in       flattened length fields, requester i at [i*LW +: LW]
//   data_in      flattened payloads, requester i at [i*DW +: DW]
//   ack          one-clk one-hot pulse when a requester's fields are latched
//   grant        one-hot line owner, held from START through GAP
//   SerOut       registered serial line, idles high
//   busy         high whenever not idle
//   frame_done   one-clk pulse on GAP -> IDLE
module serial_frame_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2,
  parameter int unsigned LW   = 4,
  parameter int unsigned DW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clkEn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*PW-1:0] port_in,
  input  logic [NREQ*LW-1:0] len_in,
  input  logic [NREQ*DW-1:0] data_in,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    grant,
  output logic               SerOut,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [2:0] {StIdle, StStart, StPort, StLen, StData, StGap} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   port_q, port_d;
  logic [LW-1:0]   len_q, len_d;
  logic [DW-1:0]   data_q, data_d;
  logic            ser_q, ser_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            done_q, done_d;

  // Round-robin search starting just after the last winner.
  logic          found;
  logic [IW-1:0] win, cand;
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    cand  = rr_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = rr_q + IW'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Shifted copies give the "next" bit without variable-width bit selects.
  logic [LW-1:0] cnt_m1, len_m1;
  logic [PW-1:0] port_sh;
  logic [LW-1:0] len_sh;
  logic [DW-1:0] data_sh, data_first;
  always_comb begin
    cnt_m1     = cnt_q - 1'b1;
    len_m1     = len_q - 1'b1;
    port_sh    = port_q >> cnt_m1;
    len_sh     = len_q >> cnt_m1;
    data_sh    = data_q >> cnt_m1;
    data_first = data_q >> len_m1;
  end

  // SerOut is registered with the bit belonging to the state being entered,
  // so it always lines up with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    port_d  = port_q;
    len_d   = len_q;
    data_d  = data_q;
    ser_d   = ser_q;
    grant_d = grant_q;
    ack_d   = '0;
    done_d  = 1'b0;
    if (clkEn) begin
      unique case (state_q)
        StIdle: begin
          ser_d = 1'b1;
          if (found) begin
            port_d  = port_in[win*PW +: PW];
            len_d   = len_in[win*LW +: LW];
            data_d  = data_in[win*DW +: DW];
            grant_d = NREQ'(1) << win;
            ack_d   = NREQ'(1) << win;
            rr_d    = win;
            state_d = StStart;
            ser_d   = 1'b0;
          end
        end
        StStart: begin
          state_d = StPort;
          cnt_d   = LW'(PW - 1);
          ser_d   = port_q[PW-1];
        end
        StPort: begin
          if (cnt_q == '0) begin
            state_d = StLen;
            cnt_d   = LW'(LW - 1);
            ser_d   = len_q[LW-1];
          end else begin
            cnt_d = cnt_m1;
            ser_d = port_sh[0];
          end
        end
        StLen: begin
          if (cnt_q == '0) begin
            if (len_q == '0) begin
              state_d = StGap;
              ser_d   = 1'b1;
            end else begin
              state_d = StData;
              cnt_d   = len_m1;
              ser_d   = data_first[0];
            end
          end else begin
            cnt_d = cnt_m1;
            ser_d = len_sh[0];
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            state_d = StGap;
            ser_d   = 1'b1;
          end else begin
            cnt_d = cnt_m1;
            ser_d = data_sh[0];
          end
        end
        StGap: begin
          state_d = StIdle;
          cnt_d   = '0;
          ser_d   = 1'b1;
          grant_d = '0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = StIdle;
          ser_d   = 1'b1;
          grant_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rr_q    <= IW'(NREQ - 1);
      port_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b1;
      grant_q <= '0;
      ack_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      port_q  <= port_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign SerOut     = ser_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_frame_scheduler.sv
module tb_serial_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn;
  logic [3:0]  req;
  logic [7:0]  port_in;
  logic [15:0] len_in;
  logic [63:0] data_in;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        SerOut;
  logic        busy;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_frame_scheduler #(
    .NREQ(4),
    .PW  (2),
    .LW  (4),
    .DW  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clkEn     (clkEn),
    .req       (req),
    .port_in   (port_in),
    .len_in    (len_in),
    .data_in   (data_in),
    .ack       (ack),
    .grant     (grant),
    .SerOut    (SerOut),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Outputs are sampled and inputs driven 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i, input logic [1:0] p, input logic [3:0] l,
                            input logic [15:0] d);
    port_in[i*2 +: 2]  = p;
    len_in[i*4 +: 4]   = l;
    data_in[i*16 +: 16] = d;
  endtask

  task automatic reset_dut;
    rst   = 1'b1;
    clkEn = 1'b1;
    req   = 4'b0000;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    clkEn = 1'b1;
    req   = 4'b1111;
    tick;
    checks++; if (SerOut !== 1'b1) begin errors++; $display("FAIL reset_serout got=%b exp=1", SerOut); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    req = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_single_frame;
    logic [10:0] exp;
    reset_dut;
    set_fields(2, 2'b10, 4'd3, 16'h0005);
    exp = 11'b0_10_0011_101_1;
    req = 4'b0100;
    for (int k = 0; k < 11; k++) begin
      tick;
      if (k == 0) req = 4'b0000;
      checks++;
      if (SerOut !== exp[10-k]) begin
        errors++; $display("FAIL single_bit%0d got=%b exp=%b", k, SerOut, exp[10-k]);
      end
      checks++;
      if (ack !== ((k == 0) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL single_ack%0d got=%b", k, ack);
      end
      checks++;
      if (grant !== 4'b0100 || busy !== 1'b1) begin
        errors++; $display("FAIL single_grant%0d got grant=%b busy=%b exp 0100/1", k, grant, busy);
      end
    end
    tick;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || grant !== 4'b0000 || SerOut !== 1'b1) begin
      errors++;
      $display("FAIL single_end got done=%b busy=%b grant=%b ser=%b exp 1/0/0000/1",
               frame_done, busy, grant, SerOut);
    end
    tick;
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL single_done_width got=%b exp=0", frame_done); end
  endtask

  task automatic test_round_robin;
    logic [8:0] exp;
    logic [3:0] g;
    reset_dut;
    for (int i = 0; i < 4; i++) set_fields(i, 2'(i), 4'd1, 16'(i % 2));
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      g   = 4'b0001 << (f % 4);
      exp = {1'b0, 2'(f % 4), 4'd1, 1'((f % 4) % 2), 1'b1};
      for (int k = 0; k < 9; k++) begin
        tick;
        if (k == 0) begin
          checks++;
          if (grant !== g || ack !== g) begin
            errors++; $display("FAIL rr_grant%0d got grant=%b ack=%b exp=%b", f, grant, ack, g);
          end
        end
        checks++;
        if (SerOut !== exp[8-k]) begin
          errors++; $display("FAIL rr_f%0d_bit%0d got=%b exp=%b", f, k, SerOut, exp[8-k]);
        end
      end
      tick;
      if (f == 4) req = 4'b0000;
      checks++;
      if (frame_done !== 1'b1 || SerOut !== 1'b1 || grant !== 4'b0000) begin
        errors++;
        $display("FAIL rr_gap%0d got done=%b ser=%b grant=%b exp 1/1/0000",
                 f, frame_done, SerOut, grant);
      end
    end
  endtask

  task automatic test_zero_length;
    logic [7:0] exp;
    reset_dut;
    set_fields(1, 2'b11, 4'd0, 16'hFFFF);
    exp = 8'b0_11_0000_1;
    req = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 0) begin
        req = 4'b0000;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL zero_ack got=%b exp=0010", ack); end
      end
      checks++;
      if (SerOut !== exp[7-k]) begin
        errors++; $display("FAIL zero_bit%0d got=%b exp=%b", k, SerOut, exp[7-k]);
      end
    end
    tick;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_end got done=%b busy=%b exp 1/0", frame_done, busy);
    end
  endtask

  task automatic test_max_length;
    logic [15:0] dv;
    logic [22:0] exp;
    reset_dut;
    dv = 16'h5A5A;
    set_fields(3, 2'b01, 4'hF, dv);
    exp = {1'b0, 2'b01, 4'hF, dv[14:0], 1'b1};
    req = 4'b1000;
    for (int k = 0; k < 23; k++) begin
      tick;
      if (k == 0) req = 4'b0000;
      // Mid-frame field changes must not reach the line.
      if (k == 5) set_fields(3, 2'b10, 4'h2, 16'hA5A5);
      checks++;
      if (SerOut !== exp[22-k]) begin
        errors++; $display("FAIL max_bit%0d got=%b exp=%b", k, SerOut, exp[22-k]);
      end
    end
    tick;
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL max_end got done=%b exp=1", frame_done); end
  endtask

  task automatic test_rate_gating;
    logic [9:0] exp;
    reset_dut;
    set_fields(0, 2'b01, 4'd2, 16'h0002);
    exp = 10'b0_01_0010_10_1;
    req = 4'b0001;
    for (int c = 0; c < 44; c++) begin
      clkEn = (c % 4 == 0);
      tick;
      if (c == 0) req = 4'b0000;
      checks++;
      if (ack !== ((c == 0) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL gate_ack_c%0d got=%b", c, ack);
      end
      if (c < 40) begin
        checks++;
        if (SerOut !== exp[9-c/4] || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL gate_bit_c%0d got ser=%b done=%b exp %b/0", c, SerOut, frame_done,
                   exp[9-c/4]);
        end
      end else begin
        checks++;
        if (frame_done !== ((c == 40) ? 1'b1 : 1'b0) || busy !== 1'b0) begin
          errors++; $display("FAIL gate_done_c%0d got done=%b busy=%b", c, frame_done, busy);
        end
      end
    end
    clkEn = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    reset_dut;
    set_fields(2, 2'b01, 4'd5, 16'h001F);
    req = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      tick;
      if (k == 0) req = 4'b0000;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    req = 4'b1111;
    tick;
    checks++;
    if (SerOut !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0 || frame_done !== 1'b0 ||
        ack !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_abort got ser=%b grant=%b busy=%b done=%b ack=%b",
               SerOut, grant, busy, frame_done, ack);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (grant !== 4'b0001 || ack !== 4'b0001 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_regrant got grant=%b ack=%b done=%b exp 0001/0001/0",
               grant, ack, frame_done);
    end
    req = 4'b0000;
  endtask

  initial begin
    rst     = 1'b1;
    clkEn   = 1'b1;
    req     = 4'b0000;
    port_in = '0;
    len_in  = '0;
    data_in = '0;
    test_reset;
    test_single_frame;
    test_round_robin;
    test_zero_length;
    test_max_length;
    test_rate_gating;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
